// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_e  : arbiter FSM encoding (IDLE / BUSY / DONE)
//   OWN_*    : owner / last-grant encoding shared by the top and arb_rr2
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational pick between the CPU and the DMA requester.
//   cpu_req, dma_req : pending requests
//   last             : most recently granted requester (OWN_CPU / OWN_DMA)
//   burst_ok         : a DMA burst is in progress and has not used up its budget
//   winner           : selected requester; only meaningful when a request is pending
module arb_rr2
  import arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last,
  input  logic burst_ok,
  output logic winner
);

  always_comb begin
    winner = OWN_CPU;
    if (cpu_req && dma_req) begin
      // Contention: alternate, except that a running DMA burst may keep the port.
      if ((last == OWN_DMA) && burst_ok) winner = OWN_DMA;
      else                               winner = ~last;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between the CPU and the DMA/debug
// loader, one outstanding transaction at a time.
//   cpu_* / dma_*   : requester sides (level req held until its ready pulse)
//   mem_*           : memory port; mem_en is high only while the access is in flight
//   gnt_dma         : DMA owns the port (BUSY or DONE)
//   err             : one-cycle pulse, together with the owner's ready, on timeout
//
// state | meaning
// IDLE  | waiting for a request; picks the winner and latches its access
// BUSY  | access presented to memory, waiting for mem_ready or timeout
// DONE  | owner's ready pulse; rr pointer and burst count updated
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int DMA_BURST = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          gnt_dma,
  output logic          err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BW = $clog2(DMA_BURST + 1);
  localparam logic [TW-1:0] TMO_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [BW-1:0] BURST_MAX = BW'(DMA_BURST);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_flag_q, tmo_flag_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic            winner;
  logic            burst_ok;

  // A zero count means no burst has started yet (e.g. straight out of reset),
  // so contention then falls back to plain alternation.
  assign burst_ok = (burst_q != '0) && (burst_q < BURST_MAX);

  arb_rr2 u_rr2 (
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .last     (last_q),
    .burst_ok (burst_ok),
    .winner   (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    tmo_flag_d  = tmo_flag_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d    = winner;
          we_d       = (winner == OWN_DMA) ? dma_we    : cpu_we;
          adr_d      = (winner == OWN_DMA) ? dma_adr   : cpu_adr;
          wdata_d    = (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
          tmo_d      = '0;
          tmo_flag_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        tmo_d = tmo_q + TW'(1);
        if (mem_ready) begin
          if (!we_q) begin
            if (owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          if (owner_q == OWN_DMA) dma_rdata_d = '0;
          else                    cpu_rdata_d = '0;
          tmo_flag_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d = owner_q;
        if ((owner_q == OWN_DMA) && cpu_req) begin
          if (burst_q != BURST_MAX) burst_d = burst_q + BW'(1);
        end else begin
          burst_d = '0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DMA;
      burst_q     <= '0;
      tmo_q       <= '0;
      tmo_flag_q  <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      tmo_q       <= tmo_d;
      tmo_flag_q  <= tmo_flag_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_BUSY);
  assign mem_we    = we_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ready = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign dma_ready = (state_q == ST_DONE) && (owner_q == OWN_DMA);
  assign gnt_dma   = (state_q != ST_IDLE) && (owner_q == OWN_DMA);
  assign err       = (state_q == ST_DONE) && tmo_flag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a uses default parameters, instance b uses
// DMA_BURST=1 (plain alternation under contention). Both share all inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
  logic [31:0] cpu_adr, cpu_wdata, dma_adr, dma_wdata, mem_rdata;

  logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_adr, a_mem_wdata;
  logic        a_cpu_ready, a_dma_ready, a_mem_en, a_mem_we, a_gnt_dma, a_err;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_adr, b_mem_wdata;
  logic        b_cpu_ready, b_dma_ready, b_mem_en, b_mem_we, b_gnt_dma, b_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter u_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_rdata(a_dma_rdata), .dma_ready(a_dma_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_adr(a_mem_adr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .gnt_dma(a_gnt_dma), .err(a_err)
  );

  mem_port_arbiter #(.DMA_BURST(1)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ready(b_dma_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .gnt_dma(b_gnt_dma), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_dma;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_cpu_ready", a_cpu_ready, 0);
    chk("rst_gnt_dma", a_gnt_dma, 0);
    chk("rst_err", a_err, 0);
    rst = 1'b0;

    // CPU read, mem_ready in the first BUSY cycle
    cpu_req = 1'b1; cpu_adr = 32'h40;
    tick();
    chk("rd_mem_en", a_mem_en, 1);
    chk("rd_mem_adr", a_mem_adr, 32'h40);
    chk("rd_mem_we", a_mem_we, 0);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_mem_en_done", a_mem_en, 0);
    chk("rd_cpu_ready", a_cpu_ready, 1);
    chk("rd_cpu_rdata", a_cpu_rdata, 32'hDEADBEEF);
    chk("rd_dma_ready", a_dma_ready, 0);
    mem_ready = 1'b0; cpu_req = 1'b0;
    tick();
    chk("rd_cpu_ready_drop", a_cpu_ready, 0);

    // CPU read that never completes: times out after 16 BUSY cycles
    cpu_req = 1'b1; cpu_adr = 32'h80;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_busy_en", a_mem_en, 1);
      chk("tmo_busy_err", a_err, 0);
      tick();
    end
    chk("tmo_err", a_err, 1);
    chk("tmo_cpu_ready", a_cpu_ready, 1);
    chk("tmo_cpu_rdata", a_cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    tick();
    chk("tmo_err_drop", a_err, 0);
    chk("tmo_idle_en", a_mem_en, 0);

    // Both requesting out of reset, DMA_BURST=1: CPU, DMA, CPU, DMA
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555AAAA;
    for (int k = 0; k < 4; k++) begin
      exp_dma = (k % 2) == 1;
      tick();
      chk("alt_gnt_dma", b_gnt_dma, exp_dma);
      tick();
      chk("alt_dma_ready", b_dma_ready, exp_dma);
      chk("alt_cpu_ready", b_cpu_ready, !exp_dma);
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0;

    // DMA burst with DMA_BURST=4: D D D D C D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dma_req = 1'b1; mem_rdata = 32'h0BADF00D;
    for (int k = 0; k < 6; k++) begin
      exp_dma = (k != 4);
      tick();
      if (k == 0) cpu_req = 1'b1;
      chk("burst_gnt_dma", a_gnt_dma, exp_dma);
      tick();
      chk("burst_dma_ready", a_dma_ready, exp_dma);
      chk("burst_cpu_ready", a_cpu_ready, !exp_dma);
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    tick();

    // DMA write, mem_ready on the 5th BUSY cycle; latched fields stay put
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h100; dma_wdata = 32'h12345678;
    tick();
    dma_we = 1'b0; dma_adr = 32'hFFFF0000; dma_wdata = 32'hCAFECAFE;
    for (int i = 0; i < 5; i++) begin
      chk("wr_mem_en", a_mem_en, 1);
      chk("wr_mem_we", a_mem_we, 1);
      chk("wr_mem_adr", a_mem_adr, 32'h100);
      chk("wr_mem_wdata", a_mem_wdata, 32'h12345678);
      if (i == 4) begin
        mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
      end
      tick();
    end
    chk("wr_dma_ready", a_dma_ready, 1);
    chk("wr_dma_rdata", a_dma_rdata, 32'h0BADF00D);
    chk("wr_mem_en_done", a_mem_en, 0);
    mem_ready = 1'b0; dma_req = 1'b0;
    tick();
    chk("wr_dma_ready_drop", a_dma_ready, 0);

    // Reset during the 2nd BUSY cycle of a CPU read
    cpu_req = 1'b1; cpu_adr = 32'h2000;
    tick();
    tick();
    chk("mid_busy2_en", a_mem_en, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_mem_en", a_mem_en, 0);
    chk("mid_rst_mem_we", a_mem_we, 0);
    chk("mid_rst_mem_adr", a_mem_adr, 0);
    chk("mid_rst_mem_wdata", a_mem_wdata, 0);
    chk("mid_rst_cpu_rdata", a_cpu_rdata, 0);
    chk("mid_rst_dma_rdata", a_dma_rdata, 0);
    chk("mid_rst_cpu_ready", a_cpu_ready, 0);
    chk("mid_rst_dma_ready", a_dma_ready, 0);
    chk("mid_rst_gnt_dma", a_gnt_dma, 0);
    chk("mid_rst_err", a_err, 0);
    rst = 1'b0; dma_req = 1'b1;
    tick();
    chk("post_rst_gnt_dma", a_gnt_dma, 0);
    chk("post_rst_mem_adr", a_mem_adr, 32'h2000);
    mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
    tick();
    chk("post_rst_cpu_ready", a_cpu_ready, 1);
    chk("post_rst_cpu_rdata", a_cpu_rdata, 32'h13579BDF);
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
